// File: rtl/ad9117_spi_arbiter.sv
// ad9117_spi_arbiter: round-robin arbiter that shares one AD9117 SPI command
// engine between N_REQ requesters. It drives the engine trigger/data
// handshake, waits for completion, and routes the read-back word to the
// granted requester.
//
// Optional build macro: DAC_INIT_EN. When defined, the arbiter writes
// INIT_WORD through the engine once after reset, before it grants any
// requester.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for engine ready and a pending request
// TRIG      | one-cycle trigger pulse to the engine
// WAIT_BUSY | waiting for the engine to drop ready (transfer started)
// WAIT_DONE | waiting for the engine to raise ready (transfer finished)
// RESP      | one-cycle completion pulse to the granted requester
// INIT      | (DAC_INIT_EN only) waiting to launch the post-reset write
module ad9117_spi_arbiter #(
  parameter int N_REQ          = 2,
  parameter int SPI_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4000
`ifdef DAC_INIT_EN
  , parameter logic [SPI_WIDTH-1:0] INIT_WORD = 16'h0500
`endif
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [N_REQ-1:0]           req_valid_in,
  input  logic [N_REQ*SPI_WIDTH-1:0] req_data_in,
  output logic [N_REQ-1:0]           req_ack_out,
  output logic [N_REQ-1:0]           rsp_valid_out,
  output logic [SPI_WIDTH-1:0]       rsp_data_out,
  output logic                       spi_trigger_out,
  output logic [SPI_WIDTH-1:0]       spi_data_out,
  input  logic [SPI_WIDTH-1:0]       spi_data_in,
  input  logic                       spi_ready_in,
  output logic                       busy_out,
  output logic                       timeout_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
`ifdef DAC_INIT_EN
    , S_INIT
`endif
  } state_t;

`ifdef DAC_INIT_EN
  localparam state_t RST_STATE = S_INIT;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]       ack_d, rsp_valid_d;
  logic                   trig_d, busy_d, timeout_d;
  logic [SPI_WIDTH-1:0]   spi_data_d, rsp_data_d;
  logic                   hit;
  logic [PTR_W-1:0]       pick, cand;
  logic                   init_q;
`ifdef DAC_INIT_EN
  logic                   init_d;
`else
  // Without the init feature no transfer is ever an init write.
  assign init_q = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, next-output and round-robin selection logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    trig_d      = 1'b0;
    spi_data_d  = spi_data_out;
    rsp_data_d  = rsp_data_out;
    timeout_d   = timeout_out;
    hit         = 1'b0;
    pick        = '0;
    cand        = '0;
`ifdef DAC_INIT_EN
    init_d      = init_q;
`endif

    // First pending requester at or after rr_ptr, wrapping around.
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!hit && req_valid_in[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (spi_ready_in && hit) begin
          gnt_d       = pick;
          spi_data_d  = req_data_in[int'(pick)*SPI_WIDTH +: SPI_WIDTH];
          ack_d[pick] = 1'b1;
          rr_ptr_d    = PTR_W'((int'(pick) + 1) % N_REQ);
          state_d     = S_TRIG;
        end
      end
      S_TRIG: begin
        trig_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!spi_ready_in) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_inc == CNT_LIM) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          if (init_q) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d = '1;
            state_d    = S_RESP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (spi_ready_in) begin
          cnt_d = '0;
          if (init_q) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d = spi_data_in;
            state_d    = S_RESP;
          end
        end else if (cnt_inc == CNT_LIM) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          if (init_q) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d = '1;
            state_d    = S_RESP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        rsp_valid_d[gnt_q] = 1'b1;
        state_d            = S_IDLE;
      end
`ifdef DAC_INIT_EN
      S_INIT: begin
        if (spi_ready_in) begin
          spi_data_d = INIT_WORD;
          state_d    = S_TRIG;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef DAC_INIT_EN
    // The init write is over once the FSM falls back to IDLE.
    if (state_d == S_IDLE) init_d = 1'b0;
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State register and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q         <= RST_STATE;
      rr_ptr          <= '0;
      gnt_q           <= '0;
      cnt_q           <= '0;
      req_ack_out     <= '0;
      rsp_valid_out   <= '0;
      rsp_data_out    <= '0;
      spi_trigger_out <= 1'b0;
      spi_data_out    <= '0;
      busy_out        <= RST_BUSY;
      timeout_out     <= 1'b0;
`ifdef DAC_INIT_EN
      init_q          <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr          <= rr_ptr_d;
      gnt_q           <= gnt_d;
      cnt_q           <= cnt_d;
      req_ack_out     <= ack_d;
      rsp_valid_out   <= rsp_valid_d;
      rsp_data_out    <= rsp_data_d;
      spi_trigger_out <= trig_d;
      spi_data_out    <= spi_data_d;
      busy_out        <= busy_d;
      timeout_out     <= timeout_d;
`ifdef DAC_INIT_EN
      init_q          <= init_d;
`endif
    end
  end

endmodule

// File: tb/tb_ad9117_spi_arbiter.sv
// tb_ad9117_spi_arbiter: directed bench for ad9117_spi_arbiter with a small
// behavioural SPI engine model and a negedge monitor that logs handshakes.
module tb_ad9117_spi_arbiter;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int TO = 40;
`ifdef DAC_INIT_EN
  localparam logic BUSY_RST = 1'b1;
  localparam int   BASE     = 1;
`else
  localparam logic BUSY_RST = 1'b0;
  localparam int   BASE     = 0;
`endif

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic [N-1:0]   req_valid_in;
  logic [N*W-1:0] req_data_in;
  logic [N-1:0]   req_ack_out;
  logic [N-1:0]   rsp_valid_out;
  logic [W-1:0]   rsp_data_out;
  logic           spi_trigger_out;
  logic [W-1:0]   spi_data_out;
  logic [W-1:0]   spi_data_in;
  logic           spi_ready_in;
  logic           busy_out;
  logic           timeout_out;

  logic           eng_ready;
  logic           force_busy;
  logic           eng_stuck;
  int             eng_lat;
  logic [W-1:0]   eng_rdata;

  logic [W-1:0]   trig_log[$];
  logic [N-1:0]   ack_log[$];
  logic [N-1:0]   rsp_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  assign spi_ready_in = eng_ready & ~force_busy;

  ad9117_spi_arbiter #(
    .N_REQ(N), .SPI_WIDTH(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ack_out(req_ack_out), .rsp_valid_out(rsp_valid_out),
    .rsp_data_out(rsp_data_out), .spi_trigger_out(spi_trigger_out),
    .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
    .spi_ready_in(spi_ready_in), .busy_out(busy_out),
    .timeout_out(timeout_out)
  );

  // Engine model: drops ready on a trigger, holds it low eng_lat cycles.
  initial begin
    eng_ready   = 1'b1;
    spi_data_in = '0;
    forever begin
      @(negedge clk_in);
      if (!eng_stuck && spi_trigger_out) begin
        eng_ready = 1'b0;
        repeat (eng_lat) @(negedge clk_in);
        spi_data_in = eng_rdata;
        eng_ready   = 1'b1;
      end
    end
  end

  // Handshake log, sampled away from the active edge.
  always @(negedge clk_in) begin
    if (spi_trigger_out) trig_log.push_back(spi_data_out);
    if (req_ack_out != '0) ack_log.push_back(req_ack_out);
    if (rsp_valid_out != '0) rsp_log.push_back(rsp_valid_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input int bound, output logic [N-1:0] ack);
    logic found;
    found = 1'b0;
    ack   = '0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk_in);
      if (req_ack_out != '0) begin
        found = 1'b1;
        ack   = req_ack_out;
      end
    end
    chk({tag, "_ack_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int bound,
                          output logic [N-1:0] rv, output logic [W-1:0] rd);
    logic found;
    found = 1'b0;
    rv    = '0;
    rd    = '0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk_in);
      if (rsp_valid_out != '0) begin
        found = 1'b1;
        rv    = rsp_valid_out;
        rd    = rsp_data_out;
      end
    end
    chk({tag, "_rsp_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},     {30'd0, req_ack_out},     32'd0);
    chk({tag, "_rspv"},    {30'd0, rsp_valid_out},   32'd0);
    chk({tag, "_rspd"},    {16'd0, rsp_data_out},    32'd0);
    chk({tag, "_trig"},    {31'd0, spi_trigger_out}, 32'd0);
    chk({tag, "_spid"},    {16'd0, spi_data_out},    32'd0);
    chk({tag, "_busy"},    {31'd0, busy_out},        {31'd0, BUSY_RST});
    chk({tag, "_timeout"}, {31'd0, timeout_out},     32'd0);
    chk({tag, "_rr_ptr"},  {31'd0, dut.rr_ptr},      32'd0);
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] rv;
    logic [W-1:0] rd;
    int           acks;
    int           lat;
    logic         seen;
    logic [W-1:0] exp_words [4];
    logic [N-1:0] exp_sel   [4];

    exp_words = '{16'h0111, 16'h0222, 16'h0111, 16'h0222};
    exp_sel   = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst_n_in     = 1'b0;
    req_valid_in = '0;
    req_data_in  = '0;
    force_busy   = 1'b0;
    eng_stuck    = 1'b0;
    eng_lat      = 20;
    eng_rdata    = 16'h0042;
    repeat (3) @(negedge clk_in);
    chk_reset_outputs("rst");

    // Single request from requester 0 (released together with reset).
    req_data_in[15:0] = 16'h8500;
    req_valid_in      = 2'b01;
    rst_n_in          = 1'b1;
    wait_ack("t1", 200, a);
    req_valid_in = '0;
    chk("t1_ack", {30'd0, a}, 32'd1);
`ifdef DAC_INIT_EN
    chk("init_trig_cnt", trig_log.size(), 32'd1);
    chk("init_word", {16'd0, trig_log[0]}, 32'h0500);
    chk("init_no_rsp", rsp_log.size(), 32'd0);
`endif
    wait_rsp("t1", 100, rv, rd);
    chk("t1_rspv", {30'd0, rv}, 32'd1);
    chk("t1_rspd", {16'd0, rd}, 32'h0042);
    repeat (3) @(negedge clk_in);
    chk("t1_ack_cnt", ack_log.size(), 32'd1);
    chk("t1_trig_cnt", trig_log.size(), BASE + 1);
    chk("t1_trig_word", {16'd0, trig_log[BASE]}, 32'h8500);
    chk("t1_rsp_cnt", rsp_log.size(), 32'd1);
    chk("t1_rspd_hold", {16'd0, rsp_data_out}, 32'h0042);
    chk("t1_spid_hold", {16'd0, spi_data_out}, 32'h8500);

    // Requester 1 alone: response is routed to requester 1 only.
    req_data_in[31:16] = 16'h1234;
    eng_rdata          = 16'hBEEF;
    eng_lat            = 5;
    req_valid_in       = 2'b10;
    wait_ack("t2", 50, a);
    req_valid_in = '0;
    chk("t2_ack", {30'd0, a}, 32'd2);
    wait_rsp("t2", 50, rv, rd);
    chk("t2_rspv", {30'd0, rv}, 32'd2);
    chk("t2_rspd", {16'd0, rd}, 32'h0000BEEF);

    // Contention: both held valid, expect strict alternation from 0.
    repeat (2) @(negedge clk_in);
    trig_log.delete();
    ack_log.delete();
    rsp_log.delete();
    req_data_in  = {16'h0222, 16'h0111};
    eng_lat      = 3;
    eng_rdata    = 16'h0077;
    req_valid_in = 2'b11;
    acks = 0;
    for (int i = 0; i < 300 && acks < 4; i++) begin
      @(negedge clk_in);
      if (req_ack_out != '0) acks++;
    end
    req_valid_in = '0;
    chk("t3_ack_total", acks, 32'd4);
    repeat (30) @(negedge clk_in);
    chk("t3_ack_cnt", ack_log.size(), 32'd4);
    chk("t3_trig_cnt", trig_log.size(), 32'd4);
    chk("t3_rsp_cnt", rsp_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log.size())  chk($sformatf("t3_ack%0d", i),  {30'd0, ack_log[i]},  {30'd0, exp_sel[i]});
      if (i < trig_log.size()) chk($sformatf("t3_word%0d", i), {16'd0, trig_log[i]}, {16'd0, exp_words[i]});
      if (i < rsp_log.size())  chk($sformatf("t3_rsp%0d", i),  {30'd0, rsp_log[i]},  {30'd0, exp_sel[i]});
    end

    // Engine stuck with ready high: abort after exactly TO cycles.
    eng_stuck         = 1'b1;
    req_data_in[15:0] = 16'h0003;
    req_valid_in      = 2'b01;
    wait_ack("t4", 20, a);
    req_valid_in = '0;
    chk("t4_ack", {30'd0, a}, 32'd1);
    chk("t4_timeout_pre", {31'd0, timeout_out}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_in);
      seen = spi_trigger_out;
    end
    chk("t4_trig_seen", {31'd0, seen}, 32'd1);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < TO + 20 && !seen; i++) begin
      @(negedge clk_in);
      lat++;
      seen = (rsp_valid_out != '0);
    end
    chk("t4_abort_lat", lat, TO + 1);
    chk("t4_rspv", {30'd0, rsp_valid_out}, 32'd1);
    chk("t4_rspd", {16'd0, rsp_data_out}, 32'h0000FFFF);
    chk("t4_timeout", {31'd0, timeout_out}, 32'd1);
    eng_stuck          = 1'b0;
    eng_rdata          = 16'h5A5A;
    eng_lat            = 4;
    req_data_in[31:16] = 16'h2222;
    req_valid_in       = 2'b10;
    wait_ack("t4b", 50, a);
    req_valid_in = '0;
    chk("t4b_ack", {30'd0, a}, 32'd2);
    wait_rsp("t4b", 50, rv, rd);
    chk("t4b_rspv", {30'd0, rv}, 32'd2);
    chk("t4b_rspd", {16'd0, rd}, 32'h00005A5A);
    chk("t4b_timeout_sticky", {31'd0, timeout_out}, 32'd1);

    // Ready-low gating in IDLE.
    repeat (2) @(negedge clk_in);
    trig_log.delete();
    ack_log.delete();
    force_busy        = 1'b1;
    eng_rdata         = 16'h1111;
    req_data_in[15:0] = 16'h0444;
    req_valid_in      = 2'b01;
    repeat (8) @(negedge clk_in);
    chk("t5_no_ack", ack_log.size(), 32'd0);
    chk("t5_no_trig", trig_log.size(), 32'd0);
    chk("t5_idle", {31'd0, busy_out}, 32'd0);
    force_busy = 1'b0;
    @(negedge clk_in);
    chk("t5_ack_next_edge", {30'd0, req_ack_out}, 32'd1);
    req_valid_in = '0;
    wait_rsp("t5", 50, rv, rd);
    chk("t5_rspd", {16'd0, rd}, 32'h00001111);

    // Reset in the middle of WAIT_DONE.
    eng_lat            = 30;
    req_data_in[31:16] = 16'h3333;
    req_valid_in       = 2'b10;
    wait_ack("t6", 20, a);
    req_valid_in = '0;
    chk("t6_ack", {30'd0, a}, 32'd2);
    repeat (10) @(negedge clk_in);
    chk("t6_busy_mid", {31'd0, busy_out}, 32'd1);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    chk_reset_outputs("t6_rst");
    rst_n_in     = 1'b1;
    eng_rdata    = 16'h0999;
    eng_lat      = 5;
    req_data_in  = {16'h0666, 16'h0555};
    req_valid_in = 2'b11;
    wait_ack("t6b", 300, a);
    req_valid_in = '0;
    chk("t6b_ack_rr0", {30'd0, a}, 32'd1);
    wait_rsp("t6b", 300, rv, rd);
    chk("t6b_rspv", {30'd0, rv}, 32'd1);
    chk("t6b_rspd", {16'd0, rd}, 32'h00000999);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
